div_unit_seq: RTL and testbench
===============================

// Module: div_unit_seq
// PURPOSE
// - Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// - Replaces the single-cycle combinational divide path; the EX stage issues operands over a valid/ready
//   handshake and stalls until the quotient or remainder returns over a second handshake.
// - Uses the same alu_op encoding as the EX ALU, so the decoder needs no changes.
// PARAMETERS
// - XLEN     32  operand/result width; only 32 is supported
// - CNT_W     6  iteration counter width; must hold XLEN
// PORTS
// - clk        in   1     single clock, rising edge
// - rst        in   1     asynchronous, active-high reset
// - flush      in   1     synchronous pipeline kill; aborts any operation
// - in_valid   in   1     operands/op valid
// - in_ready   out  1     unit can accept; high only in IDLE
// - data1      in   32    dividend (rs1)
// - data2      in   32    divisor (rs2)
// - alu_op     in   5     10001 DIV, 10101 DIVU, 11001 REM, 11101 REMU
// - out_valid  out  1     result valid; held until out_ready
// - out_ready  in   1     consumer accepts result
// - result     out  32    quotient or remainder
// - busy       out  1     high in CALC or DONE
// BEHAVIOUR
// - Reset: state IDLE, out_valid=0, result=0, busy=0, counter=0; in_ready=1 once in IDLE.
// - in_ready and busy are decoded combinationally from state; all other outputs are registered.
// - IDLE: accept on in_valid&&in_ready&&!flush.
//   - Latch op and operand signs.
//   - Signed ops: latch |data1| and |data2|, so |0x80000000| = 0x80000000 unsigned.
//   - Counter=0; go to CALC.
// - CALC: one quotient bit per edge, MSB first.
//   - rem = {rem[30:0], dvd[31]}; shift dvd left.
//   - If rem>=dvs: subtract dvs and set quotient bit 1; else quotient bit 0.
//   - The subtract uses a 33-bit compare; no wrap.
// - On the 32nd CALC edge: apply sign correction, register result, go to DONE with out_valid=1.
//   - Quotient is negated if the operand signs differ (signed ops only).
//   - Remainder takes the sign of the dividend.
// - Latency: accept edge = edge 0; out_valid is visible after edge 32 (33 cycles issue-to-result).
// - DONE: result and out_valid stay stable while out_ready=0.
//   - On out_valid&&out_ready: go to IDLE, out_valid=0 on the same edge; result keeps its value.
//   - in_ready=0 in DONE; no back-to-back overlap.
// - Special results (exact RISC-V values):
//   - Divisor 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> data1.
//   - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0x00000000.
// - Any other alu_op is accepted, goes straight to DONE with result=0, out_valid after edge 0 (1-cycle).
// - flush: highest priority after rst.
//   - Any state -> IDLE, out_valid=0, counter=0.
//   - An in_valid in the same cycle is not accepted.
//   - A result in DONE is discarded.
// - Operand changes on data1/data2 after acceptance have no effect.
// - rst mid-CALC: immediate return to reset values; no partial result is ever presented.
// CONFIGURATION
// - DIV_FAST_PATH_EN defined: divisor==0 and signed overflow bypass CALC.
//   - Result is registered on the accept edge; out_valid after edge 0.
// - DIV_FAST_PATH_EN undefined: these cases run all 32 CALC edges.
//   - The special value overrides the datapath result on the final edge.
//   - Latency is identical to a normal divide.
// - Result values are identical in both builds; only latency differs.
// TESTING
// - DIVU 100/7, out_ready=1 -> result 14, out_valid exactly after edge 32; REMU same operands -> 2.
// - DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM same -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
// - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
//   - DIV_FAST_PATH_EN: out_valid after edge 0; otherwise after edge 32.
// - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; check both builds.
// - Hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0; release -> IDLE next edge.
// - Assert flush at CALC edge 10 with in_valid=1 -> IDLE, out_valid never rises, no accept.
//   - A new DIVU 9/3 then returns 3.
//   - Repeat with async rst mid-CALC -> all outputs at reset values.

Source files
------------

// File: rtl/div_unit_seq.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU. Results arrive 32 edges after accept (1 edge for illegal ops or, with DIV_FAST_PATH_EN, for div-by-zero/overflow).
// Accepts operands only when idle; holds result and out_valid until out_ready is seen.
module div_unit_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic [4:0]      alu_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0]  MINV = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d, res_q, res_d;
  logic              out_vld_q, out_vld_d;
  logic              rem_op_q, rem_op_d, neg_q, neg_d, rsign_q, rsign_d;
  logic              dz_q, dz_d, ovf_q, ovf_d;

  logic              valid_op, sgn, a_neg, b_neg, dz, ovf, fast_hit, qbit;
  logic [XLEN-1:0]   a_abs, b_abs, rem_n, dvd_n, q_fix, r_fix, res_calc;
  logic [XLEN:0]     rem_sh, diff;

  // Illegal encodings are accepted but produce zero.
  assign valid_op = alu_op[4] && (alu_op[1:0] == 2'b01);
  assign sgn      = ~alu_op[2];
  assign a_neg    = sgn & data1[XLEN-1];
  assign b_neg    = sgn & data2[XLEN-1];
  assign a_abs    = a_neg ? -data1 : data1;
  assign b_abs    = b_neg ? -data2 : data2;
  assign dz       = (data2 == '0);
  assign ovf      = sgn && (data1 == MINV) && (data2 == '1);
`ifdef DIV_FAST_PATH_EN
  assign fast_hit = dz || ovf;
`else
  assign fast_hit = 1'b0;
`endif

  // One restoring step; the shifted partial remainder keeps its carry-out bit.
  assign rem_sh = {rem_q, dvd_q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign qbit   = ~diff[XLEN];
  assign rem_n  = qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign dvd_n  = {dvd_q[XLEN-2:0], qbit};
  assign q_fix  = neg_q   ? -dvd_n : dvd_n;
  assign r_fix  = rsign_q ? -rem_n : rem_n;

  always_comb begin
    res_calc = rem_op_q ? r_fix : q_fix;
    if (dz_q) begin
      res_calc = rem_op_q ? r_fix : '1;
    end else if (ovf_q) begin
      res_calc = rem_op_q ? '0 : MINV;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    res_d     = res_q;
    out_vld_d = out_vld_q;
    rem_op_d  = rem_op_q;
    neg_d     = neg_q;
    rsign_d   = rsign_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          cnt_d = '0;
          if (!valid_op) begin
            state_d   = DONE;
            out_vld_d = 1'b1;
            res_d     = '0;
          end else if (fast_hit) begin
            state_d   = DONE;
            out_vld_d = 1'b1;
            res_d     = dz ? (alu_op[3] ? data1 : '1) : (alu_op[3] ? '0 : MINV);
          end else begin
            state_d  = CALC;
            rem_d    = '0;
            dvd_d    = a_abs;
            dvs_d    = b_abs;
            rem_op_d = alu_op[3];
            neg_d    = a_neg ^ b_neg;
            rsign_d  = a_neg;
            dz_d     = dz;
            ovf_d    = ovf;
          end
        end
      end
      CALC: begin
        rem_d = rem_n;
        dvd_d = dvd_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d   = DONE;
          out_vld_d = 1'b1;
          res_d     = res_calc;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d   = IDLE;
          out_vld_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d   = IDLE;
      out_vld_d = 1'b0;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
      out_vld_q <= 1'b0;
      rem_op_q  <= 1'b0;
      neg_q     <= 1'b0;
      rsign_q   <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      res_q     <= res_d;
      out_vld_q <= out_vld_d;
      rem_op_q  <= rem_op_d;
      neg_q     <= neg_d;
      rsign_q   <= rsign_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_vld_q;
  assign result    = res_q;

endmodule

// File: tb/tb_div_unit_seq.sv
// Scoreboard bench for div_unit_seq: expected results queued at issue, compared when out_valid rises.
module tb_div_unit_seq;

  localparam logic [4:0] OP_DIV  = 5'b10001;
  localparam logic [4:0] OP_DIVU = 5'b10101;
  localparam logic [4:0] OP_REM  = 5'b11001;
  localparam logic [4:0] OP_REMU = 5'b11101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data1 = '0;
  logic [31:0] data2 = '0;
  logic [4:0]  alu_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  div_unit_seq dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .data1(data1), .data2(data2), .alu_op(alu_op), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ov;
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ov ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:  return (b == 0) ? a : ov ? 32'h0 : 32'($signed(a) % $signed(b));
      OP_REMU: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic legal, spec;
    legal = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    spec  = (b == 0) || ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    if (!legal) return 0;
`ifdef DIV_FAST_PATH_EN
    if (spec) return 0;
`else
    if (spec) return 32;
`endif
    return 32;
  endfunction

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL issue_ready: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1; alu_op = op; data1 = a; data2 = b;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0; data1 = $urandom; data2 = $urandom; alu_op = $urandom_range(0, 31);
  endtask

  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int hold);
    int n, lat;
    logic [31:0] e, r0;
    lat = exp_lat(op, a, b);
    issue(op, a, b, exp);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    e = exp_q.pop_front();
    checks++;
    if (!out_valid) begin
      failures++;
      $display("FAIL timeout op=%b a=%h b=%h: out_valid never rose", op, a, b);
      return;
    end
    if (n != lat) begin
      failures++;
      $display("FAIL latency op=%b a=%h b=%h: got %0d edges required %0d", op, a, b, n, lat);
    end
    checks++;
    if (result !== e) begin
      failures++;
      $display("FAIL result op=%b a=%h b=%h: got %h required %h", op, a, b, result, e);
    end
    r0 = result;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      checks++;
      if (result !== r0 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL hold%0d: result=%h ov=%b ir=%b busy=%b required %h 1 0 1", k, result, out_valid, in_ready, busy, r0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || result !== e) begin
      failures++;
      $display("FAIL release: ov=%b ir=%b busy=%b result=%h required 0 1 0 %h", out_valid, in_ready, busy, result, e);
    end
  endtask

  task automatic test_reset();
    #22;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset: ov=%b result=%h busy=%b ir=%b required 0 0 0 1", out_valid, result, busy, in_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    do_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 0);
    do_op(OP_REMU, 32'd100, 32'd7, 32'd2, 0);
    do_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    do_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    do_op(OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 0);
    do_op(OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 0);
    do_op(OP_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 0);
  endtask

  task automatic test_special();
    do_op(OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    do_op(OP_REM,  32'd5, 32'd0, 32'd5, 0);
    do_op(OP_DIV,  32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, 0);
    do_op(OP_REMU, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 0);
    do_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    do_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
    do_op(5'b00011, 32'd9, 32'd3, 32'h0, 0);
  endtask

  task automatic test_hold();
    do_op(OP_DIVU, 32'd1000, 32'd10, 32'd100, 5);
  endtask

  task automatic test_random();
    logic [4:0] ops[4];
    logic [31:0] a, b;
    logic [4:0] op;
    ops = '{OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    for (int i = 0; i < 10; i++) begin
      op = ops[$urandom_range(0, 3)];
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      do_op(op, a, b, model(op, a, b), 0);
    end
  endtask

  task automatic watch_quiet(input string name);
    int rose;
    rose = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) rose = 1;
    end
    checks++;
    if (rose != 0) begin
      failures++;
      $display("FAIL %s_quiet: out_valid rose after abort, required never", name);
    end
  endtask

  task automatic test_flush();
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14);
    void'(exp_q.pop_front());
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; alu_op = OP_DIVU; data1 = 32'd50; data2 = 32'd5;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush: ir=%b busy=%b ov=%b required 1 0 0", in_ready, busy, out_valid);
    end
    watch_quiet("flush");
    do_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 0);
  endtask

  task automatic test_async_rst();
    issue(OP_DIV, 32'hFFFF_FF00, 32'd3, 32'hFFFF_FFAB);
    void'(exp_q.pop_front());
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_rst: ov=%b result=%h busy=%b ir=%b required 0 0 0 1", out_valid, result, busy, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    watch_quiet("rst");
    do_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_special();
    test_hold();
    test_random();
    test_flush();
    test_async_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
